// File: rtl/dma_sched.sv
// DMA request scheduler: arbitrates RX/TX/BDL requesters onto a single host-bus DMA engine,
// latches the winner's descriptor, runs the start/done handshake and guards it with a watchdog.
module dma_sched #(
  parameter int unsigned TMO_W = 16,
  parameter int unsigned WC_W  = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [2:0]        req_i,
  input  logic [65:0]       req_hadr_i,
  input  logic [44:0]       req_ladr_i,
  input  logic [3*WC_W-1:0] req_wcnt_i,
  input  logic [2:0]        req_dir_i,
  output logic [2:0]        gnt_o,
  output logic [2:0]        done_o,
  output logic [2:0]        err_o,
  output logic              eng_start_o,
  output logic              eng_abort_o,
  output logic [21:0]       eng_hadr_o,
  output logic [14:0]       eng_ladr_o,
  output logic [WC_W-1:0]   eng_wcnt_o,
  output logic              eng_dir_o,
  input  logic              eng_done_i,
  input  logic              eng_nxm_i
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StStart = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  // Watchdog value in the last WAIT cycle before the count would reach all-ones.
  localparam logic [TMO_W-1:0] WdLast = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [TMO_W-1:0] WdOne  = {{(TMO_W-1){1'b0}}, 1'b1};

  logic [2:0]      state_q, state_d;
  logic [2:0]      gnt_q, gnt_d;
  logic [2:0]      done_q, done_d;
  logic [2:0]      err_q, err_d;
  logic            start_q, start_d;
  logic            abort_q, abort_d;
  logic [21:0]     hadr_q, hadr_d;
  logic [14:0]     ladr_q, ladr_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic            dir_q, dir_d;
  logic            rr_q, rr_d;
  logic [TMO_W-1:0] wd_q, wd_d;

  logic [1:0]      win;
  logic [2:0]      sel_gnt;
  logic [21:0]     sel_hadr;
  logic [14:0]     sel_ladr;
  logic [WC_W-1:0] sel_wcnt;
  logic            sel_dir;

  // BDL always wins; RX/TX tie goes to whichever was not served last.
  always_comb begin
    if (req_i[2]) begin
      win = 2'd2;
    end else if (req_i[0] && req_i[1]) begin
      win = rr_q ? 2'd0 : 2'd1;
    end else if (req_i[0]) begin
      win = 2'd0;
    end else begin
      win = 2'd1;
    end
  end

  always_comb begin
    case (win)
      2'd0: begin
        sel_gnt  = 3'b001;
        sel_hadr = req_hadr_i[21:0];
        sel_ladr = req_ladr_i[14:0];
        sel_wcnt = req_wcnt_i[WC_W-1:0];
        sel_dir  = req_dir_i[0];
      end
      2'd1: begin
        sel_gnt  = 3'b010;
        sel_hadr = req_hadr_i[43:22];
        sel_ladr = req_ladr_i[29:15];
        sel_wcnt = req_wcnt_i[2*WC_W-1:WC_W];
        sel_dir  = req_dir_i[1];
      end
      default: begin
        sel_gnt  = 3'b100;
        sel_hadr = req_hadr_i[65:44];
        sel_ladr = req_ladr_i[44:30];
        sel_wcnt = req_wcnt_i[3*WC_W-1:2*WC_W];
        sel_dir  = req_dir_i[2];
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = 3'b000;
    err_d   = 3'b000;
    start_d = 1'b0;
    abort_d = 1'b0;
    hadr_d  = hadr_q;
    ladr_d  = ladr_q;
    wcnt_d  = wcnt_q;
    dir_d   = dir_q;
    rr_d    = rr_q;
    wd_d    = wd_q;
    case (state_q)
      StIdle: begin
        if (enable_i && (req_i != 3'b000)) begin
          gnt_d   = sel_gnt;
          hadr_d  = sel_hadr;
          ladr_d  = sel_ladr;
          wcnt_d  = sel_wcnt;
          dir_d   = sel_dir;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (wcnt_q == '0) begin
          done_d  = gnt_q;
          err_d   = gnt_q;
          state_d = StDone;
        end else begin
          start_d = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        wd_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        if (eng_done_i) begin
          done_d  = gnt_q;
          err_d   = gnt_q & {3{eng_nxm_i}};
          state_d = StDone;
        end else if (wd_q == WdLast) begin
          wd_d    = '1;
          abort_d = 1'b1;
          done_d  = gnt_q;
          err_d   = gnt_q;
          state_d = StDone;
        end else begin
          wd_d = wd_q + WdOne;
        end
      end
      StDone: begin
        if (gnt_q[0]) begin
          rr_d = 1'b0;
        end else if (gnt_q[1]) begin
          rr_d = 1'b1;
        end
        gnt_d   = 3'b000;
        wd_d    = '0;
        state_d = StIdle;
      end
      default: begin
        gnt_d   = 3'b000;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      gnt_q   <= 3'b000;
      done_q  <= 3'b000;
      err_q   <= 3'b000;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      hadr_q  <= '0;
      ladr_q  <= '0;
      wcnt_q  <= '0;
      dir_q   <= 1'b0;
      rr_q    <= 1'b1;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      abort_q <= abort_d;
      hadr_q  <= hadr_d;
      ladr_q  <= ladr_d;
      wcnt_q  <= wcnt_d;
      dir_q   <= dir_d;
      rr_q    <= rr_d;
      wd_q    <= wd_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign eng_start_o = start_q;
  assign eng_abort_o = abort_q;
  assign eng_hadr_o  = hadr_q;
  assign eng_ladr_o  = ladr_q;
  assign eng_wcnt_o  = wcnt_q;
  assign eng_dir_o   = dir_q;

endmodule

// File: tb/tb_dma_sched.sv
// Self-checking bench for dma_sched: transfer-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_dma_sched;
  localparam int TW   = 7;
  localparam int WCW  = 12;
  localparam int TMO  = (1 << TW) - 1;

  logic             clk;
  logic             rst_i, enable_i, eng_done_i, eng_nxm_i;
  logic [2:0]       req_i, req_dir_i;
  logic [21:0]      hadr [3];
  logic [14:0]      ladr [3];
  logic [WCW-1:0]   wcnt [3];
  logic [65:0]      req_hadr_i;
  logic [44:0]      req_ladr_i;
  logic [3*WCW-1:0] req_wcnt_i;
  logic [2:0]       gnt_o, done_o, err_o;
  logic             eng_start_o, eng_abort_o, eng_dir_o;
  logic [21:0]      eng_hadr_o;
  logic [14:0]      eng_ladr_o;
  logic [WCW-1:0]   eng_wcnt_o;

  int n_checks = 0;
  int n_errors = 0;
  bit armed = 0;
  int order[$];

  assign req_hadr_i = {hadr[2], hadr[1], hadr[0]};
  assign req_ladr_i = {ladr[2], ladr[1], ladr[0]};
  assign req_wcnt_i = {wcnt[2], wcnt[1], wcnt[0]};

  dma_sched #(.TMO_W(TW), .WC_W(WCW)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .req_i(req_i),
    .req_hadr_i(req_hadr_i), .req_ladr_i(req_ladr_i), .req_wcnt_i(req_wcnt_i),
    .req_dir_i(req_dir_i), .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o),
    .eng_start_o(eng_start_o), .eng_abort_o(eng_abort_o), .eng_hadr_o(eng_hadr_o),
    .eng_ladr_o(eng_ladr_o), .eng_wcnt_o(eng_wcnt_o), .eng_dir_o(eng_dir_o),
    .eng_done_i(eng_done_i), .eng_nxm_i(eng_nxm_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one transfer at a time, tracked by phase and WAIT-cycle count.
  localparam int PLoad = 0, PStart = 1, PWait = 2, PDone = 3;
  bit   m_act, m_rr, m_err, m_abort;
  int   m_own, m_ph, m_waited;
  logic [21:0]    m_hadr;
  logic [14:0]    m_ladr;
  logic [WCW-1:0] m_wcnt;
  logic           m_dir;

  always @(posedge clk) begin
    if (rst_i) begin
      m_act = 0; m_rr = 1; m_err = 0; m_abort = 0; m_own = 0; m_ph = PLoad; m_waited = 0;
      m_hadr = '0; m_ladr = '0; m_wcnt = '0; m_dir = 1'b0;
    end else if (!m_act) begin
      if (enable_i && req_i != 3'b000) begin
        if (req_i[2]) m_own = 2;
        else if (req_i[0] && req_i[1]) m_own = m_rr ? 0 : 1;
        else m_own = req_i[0] ? 0 : 1;
        m_hadr = hadr[m_own]; m_ladr = ladr[m_own]; m_wcnt = wcnt[m_own];
        m_dir = req_dir_i[m_own];
        m_act = 1; m_ph = PLoad; m_err = 0; m_abort = 0;
      end
    end else begin
      case (m_ph)
        PLoad: if (m_wcnt == 0) begin m_ph = PDone; m_err = 1; end else m_ph = PStart;
        PStart: begin m_ph = PWait; m_waited = 0; end
        PWait: begin
          m_waited++;
          if (eng_done_i) begin m_ph = PDone; m_err = eng_nxm_i; end
          else if (m_waited == TMO) begin m_ph = PDone; m_err = 1; m_abort = 1; end
        end
        default: begin
          if (m_own < 2) m_rr = (m_own == 1);
          m_act = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [2:0] e_gnt, e_done, e_err;
    logic [63:0] exp_v, act_v;
    if (armed) begin
      e_gnt  = m_act ? (3'b001 << m_own) : 3'b000;
      e_done = (m_act && m_ph == PDone) ? e_gnt : 3'b000;
      e_err  = (m_act && m_ph == PDone && m_err) ? e_gnt : 3'b000;
      exp_v = {e_gnt, e_done, e_err, m_act && m_ph == PStart, m_act && m_ph == PDone && m_abort,
               m_hadr, m_ladr, m_wcnt, m_dir};
      act_v = {gnt_o, done_o, err_o, eng_start_o, eng_abort_o,
               eng_hadr_o, eng_ladr_o, eng_wcnt_o, eng_dir_o};
      n_checks++;
      if (act_v !== exp_v) begin
        n_errors++;
        $display("FAIL model_cycle t=%0t: dut %h expected %h", $time, act_v, exp_v);
      end
    end
    if (done_o != 3'b000) order.push_back(done_o[0] ? 0 : (done_o[1] ? 1 : 2));
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; req_i = 3'b000; eng_done_i = 1'b0; eng_nxm_i = 1'b0;
    step(); step();
    rst_i = 1'b0;
  endtask

  task automatic wait_start();
    int i = 0;
    while (!eng_start_o && i < 20) begin step(); i++; end
    chk("start_seen", {31'd0, eng_start_o}, 32'd1);
  endtask

  task automatic run_xfer(input int lat, input logic nxm);
    wait_start();
    repeat (lat) step();
    eng_done_i = 1'b1; eng_nxm_i = nxm;
    step();
    eng_done_i = 1'b0; eng_nxm_i = 1'b0;
  endtask

  initial begin
    int cnt;
    int exp_order[6] = '{2, 2, 0, 1, 0, 1};
    rst_i = 1'b1; enable_i = 1'b1; req_i = 3'b000; req_dir_i = 3'b000;
    eng_done_i = 1'b0; eng_nxm_i = 1'b0;
    for (int k = 0; k < 3; k++) begin hadr[k] = '0; ladr[k] = '0; wcnt[k] = '0; end
    step();
    armed = 1;
    chk("reset_gnt", {29'd0, gnt_o}, 32'd0);
    chk("reset_outs", {27'd0, done_o, err_o, eng_start_o, eng_abort_o}, 32'd0);
    chk("reset_hadr", {10'd0, eng_hadr_o}, 32'd0);
    rst_i = 1'b0;

    // Single RX transfer
    hadr[0] = 22'o1000000; ladr[0] = 15'h0800; wcnt[0] = 12'd64; req_dir_i = 3'b001;
    req_i = 3'b001;
    step();
    chk("rx_gnt", {29'd0, gnt_o}, 32'd1);
    chk("rx_hadr", {10'd0, eng_hadr_o}, 32'h40000);
    chk("rx_ladr", {17'd0, eng_ladr_o}, 32'h0800);
    chk("rx_wcnt", {20'd0, eng_wcnt_o}, 32'd64);
    chk("rx_dir", {31'd0, eng_dir_o}, 32'd1);
    step();
    chk("rx_start", {31'd0, eng_start_o}, 32'd1);
    req_i = 3'b000;
    repeat (69) step();
    eng_done_i = 1'b1;
    step();
    eng_done_i = 1'b0;
    chk("rx_done", {29'd0, done_o}, 32'd1);
    chk("rx_err", {29'd0, err_o}, 32'd0);
    step(); step();

    // Priority and round-robin
    do_reset();
    hadr[1] = 22'h1234; ladr[1] = 15'h0100; wcnt[1] = 12'd5;
    hadr[2] = 22'h3abcd; ladr[2] = 15'h7000; wcnt[2] = 12'd2; req_dir_i = 3'b101;
    order.delete();
    req_i = 3'b111;
    run_xfer(10, 1'b0);
    run_xfer(10, 1'b0);
    req_i = 3'b011;
    for (int n = 0; n < 4; n++) run_xfer(10, 1'b0);
    req_i = 3'b000;
    step(); step();
    chk("order_len", order.size(), 32'd6);
    for (int n = 0; n < 6 && n < order.size(); n++) chk("order", order[n], exp_order[n]);

    // Zero-count TX
    do_reset();
    wcnt[1] = 12'd0; req_i = 3'b010;
    step();
    chk("zc_gnt", {29'd0, gnt_o}, 32'd2);
    req_i = 3'b000;
    step();
    chk("zc_done", {29'd0, done_o}, 32'd2);
    chk("zc_err", {29'd0, err_o}, 32'd2);
    chk("zc_nostart", {31'd0, eng_start_o}, 32'd0);
    step(); step();

    // Watchdog timeout
    wcnt[1] = 12'd5; req_i = 3'b001;
    wait_start();
    req_i = 3'b000;
    cnt = 0;
    while (!eng_abort_o && cnt < 300) begin step(); cnt++; end
    chk("tmo_cycle", cnt, TMO + 1);
    chk("tmo_done", {29'd0, done_o}, 32'd1);
    chk("tmo_err", {29'd0, err_o}, 32'd1);
    step(); step();

    // Bus error
    req_i = 3'b010;
    run_xfer(3, 1'b1);
    req_i = 3'b000;
    chk("nxm_done", {29'd0, done_o}, 32'd2);
    chk("nxm_err", {29'd0, err_o}, 32'd2);
    step(); step();

    // Done coincident with terminal count
    req_i = 3'b001;
    wait_start();
    req_i = 3'b000;
    repeat (TMO) step();
    eng_done_i = 1'b1;
    step();
    eng_done_i = 1'b0;
    chk("tie_done", {29'd0, done_o}, 32'd1);
    chk("tie_err", {29'd0, err_o}, 32'd0);
    chk("tie_noabort", {31'd0, eng_abort_o}, 32'd0);
    step(); step();

    // Reset during WAIT
    req_i = 3'b100;
    wait_start();
    repeat (5) step();
    rst_i = 1'b1;
    step();
    chk("mrst_outs", {27'd0, gnt_o, done_o, eng_start_o, eng_abort_o} | {2'd0, err_o, 27'd0},
        32'd0);
    chk("mrst_hadr", {10'd0, eng_hadr_o}, 32'd0);
    rst_i = 1'b0; req_i = 3'b000;
    step();

    // enable_i gating
    enable_i = 1'b0; req_i = 3'b011;
    cnt = 0;
    for (int n = 0; n < 5; n++) begin step(); if (gnt_o != 3'b000) cnt++; end
    chk("en_hold", cnt, 32'd0);
    enable_i = 1'b1;
    step();
    chk("en_gnt", {29'd0, gnt_o}, 32'd1);
    req_i = 3'b000;
    run_xfer(4, 1'b0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
